// File: rtl/fringe_generator_pkg.sv
// Shared definitions for the fringe generator.
//   - default widths for the sample path and the period counter
//   - FSM state encoding used by the top level
package fringe_generator_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_COUNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RISING  = 2'd1,
    ST_FALLING = 2'd2,
    ST_DONE    = 2'd3
  } fg_state_e;

endpackage

// File: rtl/fringe_step_clamp.sv
// Combinational next-sample computation for the triangle ramp.
// Ports:
//   cur_i     current sample (signed)
//   step_i    increment magnitude (unsigned)
//   lower_i   ramp minimum (signed)
//   upper_i   ramp maximum (signed)
//   rising_i  1 = add step and clamp at upper, 0 = subtract and clamp at lower
//   nxt_o     next sample, clamped to the active limit
//   hit_o     the active limit was reached (turnaround point)
module fringe_step_clamp
  import fringe_generator_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic signed [DATA_W-1:0] cur_i,
  input  logic        [DATA_W-1:0] step_i,
  input  logic signed [DATA_W-1:0] lower_i,
  input  logic signed [DATA_W-1:0] upper_i,
  input  logic                     rising_i,
  output logic signed [DATA_W-1:0] nxt_o,
  output logic                     hit_o
);

  // Two guard bits: one for the sign of the unsigned step, one for the
  // carry, so a full-range step against a full-range sample cannot wrap.
  localparam int EXT_W = DATA_W + 2;

  logic signed [EXT_W-1:0] cur_x;
  logic signed [EXT_W-1:0] step_x;
  logic signed [EXT_W-1:0] low_x;
  logic signed [EXT_W-1:0] up_x;
  logic signed [EXT_W-1:0] sum_x;

  assign cur_x  = {{2{cur_i[DATA_W-1]}}, cur_i};
  assign step_x = {2'b00, step_i};
  assign low_x  = {{2{lower_i[DATA_W-1]}}, lower_i};
  assign up_x   = {{2{upper_i[DATA_W-1]}}, upper_i};

  always_comb begin
    sum_x = rising_i ? (cur_x + step_x) : (cur_x - step_x);
    hit_o = rising_i ? (sum_x >= up_x) : (sum_x <= low_x);
    if (hit_o) begin
      nxt_o = rising_i ? upper_i : lower_i;
    end else begin
      nxt_o = sum_x[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/fringe_generator.sv
// Triangle-wave (fringe) generator with an AXI-Stream master output.
// Ramps from lower to upper and back in steps of FG_step, counting
// completed periods and stopping after FG_period_limit periods (0 = run
// until FG_enable drops).
// Ports:
//   SYS_aclk, SYS_areset            clock, synchronous active-high reset
//   FG_enable                       start request / abort when low
//   FG_lower_limit, FG_upper_limit  signed ramp bounds (latched at start)
//   FG_step                         unsigned increment (0 behaves as 1)
//   FG_period_limit                 periods to emit, 0 = unlimited
//   M_AXIS_tvalid/tready/tdata      sample stream
//   FG_busy                         ramp in progress
//   FG_done                         one-cycle pulse when the limit is reached
//   FG_error                        sticky bad-bounds flag
//   FG_period_count                 completed periods since start
module fringe_generator
  import fringe_generator_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = DEF_DATA_W,
  parameter int COUNT_WIDTH      = DEF_COUNT_W
) (
  input  logic                               SYS_aclk,
  input  logic                               SYS_areset,
  input  logic                               FG_enable,
  input  logic signed [AXIS_TDATA_WIDTH-1:0] FG_lower_limit,
  input  logic signed [AXIS_TDATA_WIDTH-1:0] FG_upper_limit,
  input  logic        [AXIS_TDATA_WIDTH-1:0] FG_step,
  input  logic        [COUNT_WIDTH-1:0]      FG_period_limit,
  output logic                               M_AXIS_tvalid,
  input  logic                               M_AXIS_tready,
  output logic signed [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                               FG_busy,
  output logic                               FG_done,
  output logic                               FG_error,
  output logic        [COUNT_WIDTH-1:0]      FG_period_count
);

  localparam logic [AXIS_TDATA_WIDTH-1:0] STEP_ONE = AXIS_TDATA_WIDTH'(1);

  fg_state_e state_q, state_d;

  logic signed [AXIS_TDATA_WIDTH-1:0] lower_q, lower_d;
  logic signed [AXIS_TDATA_WIDTH-1:0] upper_q, upper_d;
  logic        [AXIS_TDATA_WIDTH-1:0] step_q, step_d;
  logic        [COUNT_WIDTH-1:0]      limit_q, limit_d;
  logic signed [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                               tvalid_q, tvalid_d;
  logic        [COUNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                               done_q, done_d;
  logic                               error_q, error_d;

  logic                               hs;
  logic                               cfg_ok;
  logic                               period_end;
  logic signed [AXIS_TDATA_WIDTH-1:0] nxt;
  logic                               hit;

  assign hs         = tvalid_q & M_AXIS_tready;
  assign cfg_ok     = (FG_lower_limit < FG_upper_limit);
  // Only true while the lower sample that closed the final period is on
  // the bus; its handshake ends the run.
  assign period_end = (limit_q != '0) && (cnt_q == limit_q);

  fringe_step_clamp #(
    .DATA_W (AXIS_TDATA_WIDTH)
  ) u_clamp (
    .cur_i    (tdata_q),
    .step_i   (step_q),
    .lower_i  (lower_q),
    .upper_i  (upper_q),
    .rising_i (state_q == ST_RISING),
    .nxt_o    (nxt),
    .hit_o    (hit)
  );

  always_ff @(posedge SYS_aclk) begin
    if (SYS_areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (FG_enable && cfg_ok) state_d = ST_RISING;
      end
      ST_RISING: begin
        if (hs) begin
          if (!FG_enable)      state_d = ST_IDLE;
          else if (period_end) state_d = ST_DONE;
          else if (hit)        state_d = ST_FALLING;
        end
      end
      ST_FALLING: begin
        if (hs) begin
          if (!FG_enable) state_d = ST_IDLE;
          else if (hit)   state_d = ST_RISING;
        end
      end
      ST_DONE: begin
        if (!FG_enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    FG_busy = (state_q == ST_RISING) || (state_q == ST_FALLING);
  end

  always_comb begin
    lower_d  = lower_q;
    upper_d  = upper_q;
    step_d   = step_q;
    limit_d  = limit_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    cnt_d    = cnt_q;
    error_d  = error_q;
    unique case (state_q)
      ST_IDLE: begin
        if (FG_enable) begin
          if (cfg_ok) begin
            lower_d  = FG_lower_limit;
            upper_d  = FG_upper_limit;
            step_d   = (FG_step == '0) ? STEP_ONE : FG_step;
            limit_d  = FG_period_limit;
            tdata_d  = FG_lower_limit;
            tvalid_d = 1'b1;
            cnt_d    = '0;
            error_d  = 1'b0;
          end else begin
            error_d  = 1'b1;
          end
        end
      end
      ST_RISING, ST_FALLING: begin
        if (hs) begin
          if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
            tvalid_d = 1'b0;
          end else begin
            tdata_d = nxt;
            // Reaching lower while falling closes a period; saturate
            // rather than wrap when running unlimited.
            if ((state_q == ST_FALLING) && hit && (cnt_q != '1)) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_ff @(posedge SYS_aclk) begin
    if (SYS_areset) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  // Latched run configuration; only meaningful after a valid start.
  always_ff @(posedge SYS_aclk) begin
    lower_q <= lower_d;
    upper_q <= upper_d;
    step_q  <= step_d;
    limit_q <= limit_d;
  end

  assign M_AXIS_tvalid   = tvalid_q;
  assign M_AXIS_tdata    = tdata_q;
  assign FG_done         = done_q;
  assign FG_error        = error_q;
  assign FG_period_count = cnt_q;

endmodule

// File: tb/tb_fringe_generator.sv
module tb_fringe_generator;

  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic signed [DW-1:0] lower;
  logic signed [DW-1:0] upper;
  logic        [DW-1:0] step;
  logic        [CW-1:0] plimit;
  logic                 tvalid;
  logic                 tready;
  logic signed [DW-1:0] tdata;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic        [CW-1:0] pcount;

  fringe_generator #(
    .AXIS_TDATA_WIDTH (DW),
    .COUNT_WIDTH      (CW)
  ) dut (
    .SYS_aclk        (clk),
    .SYS_areset      (rst),
    .FG_enable       (enable),
    .FG_lower_limit  (lower),
    .FG_upper_limit  (upper),
    .FG_step         (step),
    .FG_period_limit (plimit),
    .M_AXIS_tvalid   (tvalid),
    .M_AXIS_tready   (tready),
    .M_AXIS_tdata    (tdata),
    .FG_busy         (busy),
    .FG_done         (done),
    .FG_error        (error),
    .FG_period_count (pcount)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_err = 0;
  longint exp_q[$];
  int     n_done  = 0;
  int     n_valid = 0;
  int     n_extra = 0;
  logic   stall_prev = 1'b0;
  longint stall_data = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (done)   n_done++;
      if (tvalid) n_valid++;
      if (stall_prev) begin
        check_val("hold_valid", longint'(tvalid), 1);
        check_val("hold_data", longint'(tdata), stall_data);
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_extra++;
          check_val("extra_sample", n_extra, 0);
        end else begin
          check_val("sample", longint'(tdata), exp_q.pop_front());
        end
      end
      stall_prev = tvalid && !tready;
      stall_data = longint'(tdata);
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_tvalid"}, longint'(tvalid), 0);
    check_val({pfx, "_tdata"}, longint'(tdata), 0);
    check_val({pfx, "_busy"}, longint'(busy), 0);
    check_val({pfx, "_done"}, longint'(done), 0);
    check_val({pfx, "_error"}, longint'(error), 0);
    check_val({pfx, "_count"}, longint'(pcount), 0);
  endtask

  // Reference ramp: pushes up to maxn samples, stops after the lower
  // sample that completes period lim (lim != 0). Returns the final count.
  task automatic model(input longint lo, input longint up, input longint st,
                       input int lim, input int maxn, output int cnt);
    longint cur;
    int     n;
    bit     rising;
    if (st == 0) st = 1;
    cur = lo; n = 1; cnt = 0; rising = 1'b1;
    exp_q.push_back(cur);
    while (n < maxn && !(lim != 0 && cnt == lim)) begin
      if (rising) begin
        cur = cur + st;
        if (cur >= up) begin cur = up; rising = 1'b0; end
      end else begin
        cur = cur - st;
        if (cur <= lo) begin
          cur = lo; rising = 1'b1;
          if (cnt < CMAX) cnt++;
        end
      end
      exp_q.push_back(cur);
      n++;
    end
  endtask

  task automatic set_cfg(input int lo, input int up, input int st, input int lim);
    lower  = DW'(lo);
    upper  = DW'(up);
    step   = DW'(st);
    plimit = CW'(lim);
  endtask

  // Runs a limited stream to completion; samples must already be queued.
  task automatic run_limited(input string tag, input bit toggle, input int lim);
    n_done = 0;
    tready = 1'b1;
    enable = 1'b1;
    check_val({tag, "_pre_valid"}, longint'(tvalid), 0);
    tick();
    check_val({tag, "_first_valid"}, longint'(tvalid), 1);
    check_val({tag, "_err_clear"}, longint'(error), 0);
    check_val({tag, "_busy"}, longint'(busy), 1);
    for (int i = 0; i < 400 && n_done == 0; i++) begin
      tready = toggle ? ~tready : 1'b1;
      tick();
    end
    check_val({tag, "_done_seen"}, n_done, 1);
    tready = 1'b1;
    repeat (3) tick();
    check_val({tag, "_done_pulses"}, n_done, 1);
    check_val({tag, "_tvalid_off"}, longint'(tvalid), 0);
    check_val({tag, "_busy_off"}, longint'(busy), 0);
    check_val({tag, "_count"}, longint'(pcount), lim);
    check_val({tag, "_left"}, exp_q.size(), 0);
    enable = 1'b0;
    repeat (2) tick();
    check_val({tag, "_idle"}, longint'(busy), 0);
  endtask

  int seq35[17] = '{-10, -5, 0, 5, 10, 5, 0, -5, -10, -5, 0, 5, 10, 5, 0, -5, -10};
  int seq36[7]  = '{-10, -3, 4, 10, 3, -4, -10};

  initial begin
    int cnt_exp;
    rst = 1'b1; enable = 1'b0; tready = 1'b0;
    set_cfg(0, 0, 0, 0);
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Basic two-period ramp.
    set_cfg(-10, 10, 5, 2);
    foreach (seq35[i]) exp_q.push_back(seq35[i]);
    run_limited("basic", 1'b0, 2);

    // Step that overshoots both limits.
    set_cfg(-10, 10, 7, 1);
    foreach (seq36[i]) exp_q.push_back(seq36[i]);
    run_limited("clamp", 1'b0, 1);

    // Backpressure on every other cycle.
    set_cfg(-10, 10, 5, 2);
    foreach (seq35[i]) exp_q.push_back(seq35[i]);
    run_limited("toggle", 1'b1, 2);

    // Inverted bounds: error, no output; then a good start clears it.
    set_cfg(10, -10, 5, 1);
    n_valid = 0;
    enable = 1'b1;
    repeat (4) tick();
    check_val("cfg_error", longint'(error), 1);
    check_val("cfg_no_valid", n_valid, 0);
    check_val("cfg_not_busy", longint'(busy), 0);
    set_cfg(-10, 10, 5, 1);
    model(-10, 10, 5, 1, 1000, cnt_exp);
    run_limited("recover", 1'b0, cnt_exp);

    // Abort while the sample 5 is stalled.
    set_cfg(-10, 10, 5, 0);
    model(-10, 10, 5, 0, 4, cnt_exp);
    n_done = 0;
    tready = 1'b1;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 20 && !(tvalid && tdata == 5); i++) tick();
    check_val("abort_reach", longint'(tdata), 5);
    tready = 1'b0;
    enable = 1'b0;
    repeat (3) begin
      tick();
      check_val("abort_hold", longint'(tdata), 5);
    end
    tready = 1'b1;
    tick();
    check_val("abort_tvalid", longint'(tvalid), 0);
    check_val("abort_busy", longint'(busy), 0);
    check_val("abort_done", n_done, 0);
    check_val("abort_left", exp_q.size(), 0);
    tick();

    // Reset mid-stream while tdata == 0 is pending.
    set_cfg(-10, 10, 5, 0);
    exp_q.push_back(-10);
    exp_q.push_back(-5);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 20 && !(tvalid && tdata == 0); i++) tick();
    check_val("rst_reach", longint'(tdata), 0);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    enable = 1'b0;
    tick();
    check_val("midrst_tvalid_after", longint'(tvalid), 0);
    check_val("midrst_left", exp_q.size(), 0);

    // Unlimited run with step 0 (acts as 1): period count saturates.
    set_cfg(0, 1, 0, 0);
    model(0, 1, 0, 0, 40, cnt_exp);
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (exp_q.size() == 1) begin
        enable = 1'b0;
        break;
      end
    end
    tick();
    check_val("sat_count", longint'(pcount), cnt_exp);
    check_val("sat_tvalid", longint'(tvalid), 0);
    check_val("sat_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
